// File: rtl/main_ram_sync_if.sv
// main_ram_sync_if: request/response bundle between a bus master and the main RAM model.
// Ports (master view): req, we, be, addr, wdata out; rdata, ack, busy, err in.
// Handshake: req is sampled only while the RAM is idle or acking; ack is a one-cycle pulse.
interface main_ram_sync_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 20
);
   logic                    req;
   logic                    we;
   logic [WIDTH/8-1:0]      be;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [WIDTH-1:0]        wdata;
   logic [WIDTH-1:0]        rdata;
   logic                    ack;
   logic                    busy;
   logic                    err;

   modport master (
      output req, we, be, addr, wdata,
      input  rdata, ack, busy, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output rdata, ack, busy, err
   );
endinterface

// File: rtl/main_ram_sync.sv
// main_ram_sync: synchronous single-port main-memory model with byte-lane writes and wait states.
// Latency: request sampled at edge C, ack high in the cycle after edge C+WAIT_STATES; one transfer per WAIT_STATES+1 cycles.
// Backpressure: busy covers the wait cycles; req is ignored while waiting and re-sampled in the ack cycle (back-to-back).
// Ports: clk, reset (sync, active high), bus (main_ram_sync_if.slave: req/we/be/addr/wdata in, rdata/ack/busy/err out).
// Optional macro MAIN_RAM_BOUNDS_EN: out-of-range addresses raise err and are not committed;
// without it err is 0 and addresses wrap modulo DEPTH.
module main_ram_sync #(
   parameter int WIDTH       = 16,
   parameter int ADDR_WIDTH  = 20,
   parameter int DEPTH       = 2048,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             reset,
   main_ram_sync_if.slave   bus
);
   localparam int NB = WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                  state;
   logic [3:0]              wcnt;
   logic                    ack_q;
   logic                    busy_q;
   logic [WIDTH-1:0]        rdata_q;

   // Request captured at the sampling edge, used when it completes out of WAIT.
   logic                    cap_we;
   logic [NB-1:0]           cap_be;
   logic [ADDR_WIDTH-1:0]   cap_addr;
   logic [WIDTH-1:0]        cap_wdata;

   logic [WIDTH-1:0]        mem [DEPTH];

   // Transaction being committed this edge: with zero wait states it is the
   // live bus request, otherwise the one held in the capture registers.
   logic                    c_we;
   logic [NB-1:0]           c_be;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [WIDTH-1:0]        c_wdata;
   logic                    commit_en;
   logic                    c_ok;
   logic [IW-1:0]           c_idx;

   always_comb begin
      c_we    = bus.we;
      c_be    = bus.be;
      c_addr  = bus.addr;
      c_wdata = bus.wdata;
      if (state == S_WAIT) begin
         c_we    = cap_we;
         c_be    = cap_be;
         c_addr  = cap_addr;
         c_wdata = cap_wdata;
      end
   end

   assign commit_en = (state == S_WAIT) ? (wcnt == LAST)
                                        : (bus.req && (WAIT_STATES == 0));
   assign c_idx     = IW'(c_addr % ADDR_WIDTH'(DEPTH));

`ifdef MAIN_RAM_BOUNDS_EN
   logic err_q;
   assign c_ok    = (c_addr < ADDR_WIDTH'(DEPTH));
   assign bus.err = err_q;
`else
   assign c_ok    = 1'b1;
   assign bus.err = 1'b0;
`endif

   assign bus.ack   = ack_q;
   assign bus.busy  = busy_q;
   assign bus.rdata = rdata_q;

   // Memory contents survive reset; reset only blocks a commit on its edge.
   always_ff @(posedge clk) begin
      if (!reset && commit_en && c_we && c_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (c_be[i]) begin
               mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         wcnt      <= 4'd0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         rdata_q   <= '0;
         cap_we    <= 1'b0;
         cap_be    <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
`ifdef MAIN_RAM_BOUNDS_EN
         err_q     <= 1'b0;
`endif
      end else begin
         ack_q  <= 1'b0;
         busy_q <= 1'b0;
`ifdef MAIN_RAM_BOUNDS_EN
         err_q  <= 1'b0;
`endif
         case (state)
            S_IDLE, S_ACK: begin
               if (bus.req) begin
                  cap_we    <= bus.we;
                  cap_be    <= bus.be;
                  cap_addr  <= bus.addr;
                  cap_wdata <= bus.wdata;
                  wcnt      <= 4'd0;
                  if (WAIT_STATES == 0) begin
                     state <= S_ACK;
                     ack_q <= 1'b1;
                  end else begin
                     state  <= S_WAIT;
                     busy_q <= 1'b1;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (wcnt == LAST) begin
                  state <= S_ACK;
                  ack_q <= 1'b1;
                  wcnt  <= 4'd0;
               end else begin
                  wcnt   <= wcnt + 4'd1;
                  busy_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (commit_en) begin
            if (!c_we) begin
               rdata_q <= c_ok ? mem[c_idx] : '0;
            end
`ifdef MAIN_RAM_BOUNDS_EN
            err_q <= !c_ok;
            if (!c_ok) begin
               $display("Main RAM bounds error addr 0x%0h", c_addr);
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_main_ram_sync.sv
// tb_main_ram_sync: directed, table-driven bench for main_ram_sync.
// Three instances (WAIT_STATES 2, 0, 15) share clk/reset and the we/be/addr/wdata lines;
// each has its own req so only one is active at a time.
module tb_main_ram_sync;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_v;
   logic        we_s;
   logic [1:0]  be_s;
   logic [19:0] addr_s;
   logic [15:0] wdata_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   main_ram_sync_if if0 ();
   main_ram_sync_if if1 ();
   main_ram_sync_if if2 ();

   assign if0.req = req_v[0]; assign if0.we = we_s; assign if0.be = be_s;
   assign if0.addr = addr_s;  assign if0.wdata = wdata_s;
   assign if1.req = req_v[1]; assign if1.we = we_s; assign if1.be = be_s;
   assign if1.addr = addr_s;  assign if1.wdata = wdata_s;
   assign if2.req = req_v[2]; assign if2.we = we_s; assign if2.be = be_s;
   assign if2.addr = addr_s;  assign if2.wdata = wdata_s;

   main_ram_sync #(.WAIT_STATES(2))  dut0 (.clk(clk), .reset(reset), .bus(if0));
   main_ram_sync #(.WAIT_STATES(0))  dut1 (.clk(clk), .reset(reset), .bus(if1));
   main_ram_sync #(.WAIT_STATES(15)) dut2 (.clk(clk), .reset(reset), .bus(if2));

   function automatic logic get_ack(input int d);
      case (d) 0: return if0.ack; 1: return if1.ack; default: return if2.ack; endcase
   endfunction
   function automatic logic get_busy(input int d);
      case (d) 0: return if0.busy; 1: return if1.busy; default: return if2.busy; endcase
   endfunction
   function automatic logic get_err(input int d);
      case (d) 0: return if0.err; 1: return if1.err; default: return if2.err; endcase
   endfunction
   function automatic logic [15:0] get_rdata(input int d);
      case (d) 0: return if0.rdata; 1: return if1.rdata; default: return if2.rdata; endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge with the DUT idle. lat counts rising edges
   // from request until ack is seen (1 = ack right after the sampling edge).
   task automatic txn(input int d, input logic w, input logic [1:0] b,
                      input logic [19:0] a, input logic [15:0] wd,
                      output int lat, output logic [15:0] rd, output logic e,
                      output logic busy_pre_all, output logic busy_pre_any,
                      output logic busy_at_ack, output logic ack_after);
      we_s = w; be_s = b; addr_s = a; wdata_s = wd;
      req_v[d] = 1'b1;
      @(negedge clk);
      req_v[d] = 1'b0;
      lat = 1; busy_pre_all = 1'b1; busy_pre_any = 1'b0;
      while (!get_ack(d) && lat < 40) begin
         busy_pre_all = busy_pre_all & get_busy(d);
         busy_pre_any = busy_pre_any | get_busy(d);
         @(negedge clk);
         lat++;
      end
      rd = get_rdata(d);
      e = get_err(d);
      busy_at_ack = get_busy(d);
      @(negedge clk);
      ack_after = get_ack(d);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  be;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;   // rdata expected on the ack (writes leave it unchanged)
   } vec_t;

   vec_t vt [15];

   initial begin
      int lat;
      logic [15:0] rd;
      logic e, bpa, bpy, bak, aft;
      int cyc, nack, bad_busy, bad_ack;
      logic [15:0] b2b_exp [4];

      vt[0]  = '{1'b1, 2'b11, 20'h00005, 16'hBEEF, 16'h0000};
      vt[1]  = '{1'b0, 2'b11, 20'h00005, 16'h0000, 16'hBEEF};
      vt[2]  = '{1'b1, 2'b11, 20'h00009, 16'h1234, 16'hBEEF};
      vt[3]  = '{1'b1, 2'b10, 20'h00009, 16'hAB00, 16'hBEEF};
      vt[4]  = '{1'b0, 2'b11, 20'h00009, 16'h0000, 16'hAB34};
      vt[5]  = '{1'b1, 2'b01, 20'h00009, 16'h00FF, 16'hAB34};
      vt[6]  = '{1'b1, 2'b00, 20'h00009, 16'hFFFF, 16'hAB34};
      vt[7]  = '{1'b0, 2'b11, 20'h00009, 16'h0000, 16'hABFF};
      vt[8]  = '{1'b1, 2'b11, 20'h00000, 16'h1111, 16'hABFF};
      vt[9]  = '{1'b1, 2'b11, 20'h00001, 16'h2222, 16'hABFF};
      vt[10] = '{1'b1, 2'b11, 20'h00002, 16'h3333, 16'hABFF};
      vt[11] = '{1'b1, 2'b11, 20'h00003, 16'h4444, 16'hABFF};
      vt[12] = '{1'b1, 2'b11, 20'h00007, 16'h7777, 16'hABFF};
      vt[13] = '{1'b0, 2'b00, 20'h00005, 16'h0000, 16'hBEEF};
      vt[14] = '{1'b0, 2'b01, 20'h00001, 16'h0000, 16'h2222};
      b2b_exp[0] = 16'h1111; b2b_exp[1] = 16'h2222;
      b2b_exp[2] = 16'h3333; b2b_exp[3] = 16'h4444;

      // Reset state, with a request pending to show reset takes priority.
      reset = 1'b1; req_v = 3'b111; we_s = 1'b1; be_s = 2'b11;
      addr_s = 20'h0; wdata_s = 16'hDEAD;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ack%0d", d),   32'(get_ack(d)),   32'h0);
         chk($sformatf("rst_busy%0d", d),  32'(get_busy(d)),  32'h0);
         chk($sformatf("rst_rdata%0d", d), 32'(get_rdata(d)), 32'h0);
         chk($sformatf("rst_err%0d", d),   32'(get_err(d)),   32'h0);
      end
      req_v = 3'b000;
      reset = 1'b0;
      @(negedge clk);

      // Table: single transactions on the 2-wait-state instance.
      for (int i = 0; i < 15; i++) begin
         txn(0, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, lat, rd, e, bpa, bpy, bak, aft);
         chk($sformatf("v%0d_lat", i),       32'(lat), 32'd3);
         chk($sformatf("v%0d_rdata", i),     32'(rd),  32'(vt[i].exp_rdata));
         chk($sformatf("v%0d_err", i),       32'(e),   32'h0);
         chk($sformatf("v%0d_busy_wait", i), 32'(bpa), 32'h1);
         chk($sformatf("v%0d_busy_ack", i),  32'(bak), 32'h0);
         chk($sformatf("v%0d_ack_pulse", i), 32'(aft), 32'h0);
      end

      // Back-to-back: req held over four reads of addresses 0..3.
      we_s = 1'b0; be_s = 2'b11; addr_s = 20'h0; req_v[0] = 1'b1;
      nack = 0; bad_busy = 0;
      for (cyc = 1; cyc <= 18; cyc++) begin
         @(negedge clk);
         if (cyc <= 12 && (if0.busy !== !if0.ack)) bad_busy++;
         if (cyc > 12 && if0.busy !== 1'b0) bad_busy++;
         if (if0.ack) begin
            if (nack < 4) begin
               chk($sformatf("b2b_cycle%0d", nack), 32'(cyc), 32'(3 * (nack + 1)));
               chk($sformatf("b2b_rdata%0d", nack), 32'(if0.rdata), 32'(b2b_exp[nack]));
            end
            nack++;
            if (nack < 4) addr_s = 20'(nack);
            else req_v[0] = 1'b0;
         end
      end
      chk("b2b_ack_count", 32'(nack), 32'd4);
      chk("b2b_busy", 32'(bad_busy), 32'd0);

      // Reset during WAIT (k=1) and on the edge that would enter ACK (k=2).
      for (int k = 1; k <= 2; k++) begin
         we_s = 1'b1; be_s = 2'b11; addr_s = 20'h00007; wdata_s = 16'h5555;
         req_v[0] = 1'b1;
         @(negedge clk);
         req_v[0] = 1'b0;
         bad_ack = 0;
         if (if0.ack) bad_ack++;
         if (k == 2) begin
            @(negedge clk);
            if (if0.ack) bad_ack++;
         end
         reset = 1'b1;
         @(negedge clk);
         if (if0.ack) bad_ack++;
         chk($sformatf("rstmid%0d_busy", k),  32'(if0.busy),  32'h0);
         chk($sformatf("rstmid%0d_rdata", k), 32'(if0.rdata), 32'h0);
         chk($sformatf("rstmid%0d_err", k),   32'(if0.err),   32'h0);
         @(negedge clk);
         if (if0.ack) bad_ack++;
         reset = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (if0.ack) bad_ack++;
         end
         chk($sformatf("rstmid%0d_no_ack", k), 32'(bad_ack), 32'd0);
         txn(0, 1'b0, 2'b11, 20'h00007, 16'h0, lat, rd, e, bpa, bpy, bak, aft);
         chk($sformatf("rstmid%0d_lat", k),   32'(lat), 32'd3);
         chk($sformatf("rstmid%0d_old", k),   32'(rd),  32'h7777);
      end

      // Zero wait states: ack right after the sampling edge, busy never high.
      txn(1, 1'b1, 2'b11, 20'h00003, 16'h3C3C, lat, rd, e, bpa, bpy, bak, aft);
      chk("ws0_wr_lat", 32'(lat), 32'd1);
      chk("ws0_wr_busy", 32'(bpy | bak), 32'h0);
      chk("ws0_wr_pulse", 32'(aft), 32'h0);
      txn(1, 1'b0, 2'b11, 20'h00003, 16'h0, lat, rd, e, bpa, bpy, bak, aft);
      chk("ws0_rd_lat", 32'(lat), 32'd1);
      chk("ws0_rd_data", 32'(rd), 32'h3C3C);
      chk("ws0_rd_busy", 32'(bpy | bak), 32'h0);

      // Fifteen wait states.
      txn(2, 1'b1, 2'b11, 20'h00004, 16'h4D4D, lat, rd, e, bpa, bpy, bak, aft);
      chk("ws15_wr_lat", 32'(lat), 32'd16);
      chk("ws15_wr_busy", 32'(bpa), 32'h1);
      txn(2, 1'b0, 2'b11, 20'h00004, 16'h0, lat, rd, e, bpa, bpy, bak, aft);
      chk("ws15_rd_lat", 32'(lat), 32'd16);
      chk("ws15_rd_data", 32'(rd), 32'h4D4D);
      chk("ws15_rd_busy_ack", 32'(bak), 32'h0);

      // Address 0x800 is out of range for DEPTH=2048 / aliases address 0.
      txn(0, 1'b1, 2'b11, 20'h00800, 16'hCAFE, lat, rd, e, bpa, bpy, bak, aft);
      chk("bnd_wr_lat", 32'(lat), 32'd3);
`ifdef MAIN_RAM_BOUNDS_EN
      chk("bnd_wr_err", 32'(e), 32'h1);
      chk("bnd_err_pulse", 32'(if0.err), 32'h0);
      txn(0, 1'b0, 2'b11, 20'h00000, 16'h0, lat, rd, e, bpa, bpy, bak, aft);
      chk("bnd_addr0", 32'(rd), 32'h1111);
      chk("bnd_addr0_err", 32'(e), 32'h0);
      txn(0, 1'b0, 2'b11, 20'h00800, 16'h0, lat, rd, e, bpa, bpy, bak, aft);
      chk("bnd_rd_data", 32'(rd), 32'h0);
      chk("bnd_rd_err", 32'(e), 32'h1);
`else
      chk("bnd_wr_err", 32'(e), 32'h0);
      txn(0, 1'b0, 2'b11, 20'h00000, 16'h0, lat, rd, e, bpa, bpy, bak, aft);
      chk("bnd_alias", 32'(rd), 32'hCAFE);
      chk("bnd_alias_err", 32'(e), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
